// File: rtl/calc_port_align.sv
// Output-alignment stage: each channel delays {data, resp} by a run-time programmable
// number of cycles; a delay change is held pending until that channel has no response in flight.
module calc_port_align #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_DLY   = 3,
  parameter int DLY_W     = 2
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  input  logic [NUM_PORTS*2-1:0]      in_resp,
  input  logic                        cfg_wr,
  input  logic [2:0]                  cfg_port,
  input  logic [DLY_W-1:0]            cfg_dly,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic [NUM_PORTS*2-1:0]      out_resp,
  output logic [NUM_PORTS-1:0]        cfg_pend,
  output logic                        cfg_err
);
  localparam int CNT_W = $clog2(MAX_DLY + 2);

  typedef enum logic {ST_RUN, ST_PEND} state_e;

  logic [7:0]              port_legal;
  logic [(1<<DLY_W)-1:0]   dly_legal;
  logic                    cfg_ok;
  logic                    err_d, err_q;

  // Legality decoded through constant lookup masks so no comparison is degenerate for any parameter set.
  for (genvar gi = 0; gi < 8; gi++) begin : g_port_legal
    assign port_legal[gi] = (gi < NUM_PORTS);
  end

  for (genvar gi = 0; gi < (1 << DLY_W); gi++) begin : g_dly_legal
    assign dly_legal[gi] = (gi <= MAX_DLY);
  end

  assign cfg_ok = port_legal[cfg_port] && dly_legal[cfg_dly];
  assign err_d  = cfg_wr && !cfg_ok;

  always_ff @(posedge c_clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign cfg_err = err_q;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ch
    state_e            state_q, state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [DLY_W-1:0]  lat_q, lat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sd_q [MAX_DLY];
    logic [DATA_W-1:0] sd_d [MAX_DLY];
    logic [1:0]        sr_q [MAX_DLY];
    logic [1:0]        sr_d [MAX_DLY];
    logic [DATA_W-1:0] od_q, od_d;
    logic [1:0]        or_q, or_d;
    logic [DATA_W-1:0] ch_data;
    logic [1:0]        ch_resp;
    logic              wr_hit;
    logic              drained;

    assign ch_data = in_data[gi*DATA_W +: DATA_W];
    assign ch_resp = in_resp[gi*2 +: 2];
    assign wr_hit  = cfg_wr && cfg_ok && (cfg_port == 3'(gi));
    assign drained = (cnt_q == '0) && (ch_resp == 2'b00);

    always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      lat_d   = lat_q;
      cnt_d   = cnt_q;
      od_d    = ch_data;
      or_d    = ch_resp;

      // Output tap: delay 0 registers the input directly, delay k takes stage k-1.
      for (int k = 0; k < MAX_DLY; k++) begin
        if (32'(dly_q) == 32'(k + 1)) begin
          od_d = sd_q[k];
          or_d = sr_q[k];
        end
      end

      sd_d[0] = ch_data;
      sr_d[0] = ch_resp;
      for (int k = 1; k < MAX_DLY; k++) begin
        sd_d[k] = sd_q[k-1];
        sr_d[k] = sr_q[k-1];
      end

      if (dly_q != '0) begin
        if ((ch_resp != 2'b00) && (or_d == 2'b00)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if ((ch_resp == 2'b00) && (or_d != 2'b00)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      case (state_q)
        ST_RUN: begin
          if (wr_hit && (cfg_dly != dly_q)) begin
            lat_d   = cfg_dly;
            state_d = ST_PEND;
          end
        end
        ST_PEND: begin
          if (drained) begin
            dly_d   = lat_q;
            state_d = ST_RUN;
            // Stale responses past the old tap would surface as phantoms after a grow.
            for (int k = 0; k < MAX_DLY; k++) begin
              if (32'(k) >= 32'(dly_q)) begin
                sd_d[k] = '0;
                sr_d[k] = 2'b00;
              end
            end
          end
          if (wr_hit) begin
            if (cfg_dly == dly_d) begin
              state_d = ST_RUN;
            end else begin
              lat_d   = cfg_dly;
              state_d = ST_PEND;
            end
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    always_ff @(posedge c_clk) begin
      if (reset) begin
        state_q <= ST_RUN;
        dly_q   <= '0;
        lat_q   <= '0;
        cnt_q   <= '0;
        od_q    <= '0;
        or_q    <= 2'b00;
        for (int k = 0; k < MAX_DLY; k++) begin
          sd_q[k] <= '0;
          sr_q[k] <= 2'b00;
        end
      end else begin
        state_q <= state_d;
        dly_q   <= dly_d;
        lat_q   <= lat_d;
        cnt_q   <= cnt_d;
        od_q    <= od_d;
        or_q    <= or_d;
        for (int k = 0; k < MAX_DLY; k++) begin
          sd_q[k] <= sd_d[k];
          sr_q[k] <= sr_d[k];
        end
      end
    end

    assign out_data[gi*DATA_W +: DATA_W] = od_q;
    assign out_resp[gi*2 +: 2]           = or_q;
    assign cfg_pend[gi]                  = (state_q == ST_PEND);
  end

endmodule

// File: tb/tb_calc_port_align.sv
// Bench for calc_port_align: a delivery-schedule model predicts every output cycle by cycle,
// driven by a config table, hand-written corner sequences and random traffic.
module tb_calc_port_align;
  localparam int NP  = 4;
  localparam int DW  = 32;
  localparam int MD  = 3;
  localparam int DLW = 3;

  logic             c_clk = 1'b0;
  logic             reset = 1'b1;
  logic [NP*DW-1:0] in_data = '0;
  logic [NP*2-1:0]  in_resp = '0;
  logic             cfg_wr = 1'b0;
  logic [2:0]       cfg_port = '0;
  logic [DLW-1:0]   cfg_dly = '0;
  logic [NP*DW-1:0] out_data;
  logic [NP*2-1:0]  out_resp;
  logic [NP-1:0]    cfg_pend;
  logic             cfg_err;

  calc_port_align #(.NUM_PORTS(NP), .DATA_W(DW), .MAX_DLY(MD), .DLY_W(DLW)) dut (
    .c_clk(c_clk), .reset(reset), .in_data(in_data), .in_resp(in_resp),
    .cfg_wr(cfg_wr), .cfg_port(cfg_port), .cfg_dly(cfg_dly),
    .out_data(out_data), .out_resp(out_resp), .cfg_pend(cfg_pend), .cfg_err(cfg_err)
  );

  always #5 c_clk = ~c_clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: each nonzero response is booked for delivery at (entry cycle + active delay).
  int          act_d [NP];
  int          lat_d [NP];
  bit          pend_m [NP];
  bit          err_m;
  bit          sv   [NP][64];
  logic [DW-1:0] sdat [NP][64];
  logic [1:0]  sres [NP][64];
  logic [DW-1:0] exp_dat [NP];
  logic [1:0]  exp_res [NP];
  bit          exp_dv [NP];
  int          cyc = 0;

  typedef struct packed {
    logic       wr;
    logic [2:0] port;
    logic [2:0] dly;
    logic       exp_err;
    logic [3:0] exp_pend;
  } cfg_vec_t;
  cfg_vec_t tbl [12];

  task automatic model_edge();
    bit legal;
    int infl;
    int slot;
    logic [1:0] r;
    legal = (int'(cfg_port) < NP) && (int'(cfg_dly) <= MD);
    if (reset) begin
      err_m = 1'b0;
      for (int p = 0; p < NP; p++) begin
        act_d[p] = 0; lat_d[p] = 0; pend_m[p] = 1'b0;
        exp_res[p] = 2'b00; exp_dat[p] = '0; exp_dv[p] = 1'b1;
        for (int s = 0; s < 64; s++) sv[p][s] = 1'b0;
      end
    end else begin
      err_m = cfg_wr && !legal;
      for (int p = 0; p < NP; p++) begin
        infl = 0;
        for (int s = 0; s < 64; s++) if (sv[p][s]) infl++;
        r = in_resp[2*p +: 2];
        if (r != 2'b00) begin
          slot = (cyc + act_d[p]) % 64;
          sv[p][slot] = 1'b1;
          sdat[p][slot] = in_data[DW*p +: DW];
          sres[p][slot] = r;
        end
        if (pend_m[p] && infl == 0 && r == 2'b00) begin
          act_d[p] = lat_d[p];
          pend_m[p] = 1'b0;
        end
        if (cfg_wr && legal && int'(cfg_port) == p) begin
          if (int'(cfg_dly) == act_d[p]) pend_m[p] = 1'b0;
          else begin pend_m[p] = 1'b1; lat_d[p] = int'(cfg_dly); end
        end
        slot = cyc % 64;
        if (sv[p][slot]) begin
          exp_res[p] = sres[p][slot]; exp_dat[p] = sdat[p][slot]; exp_dv[p] = 1'b1;
          sv[p][slot] = 1'b0;
        end else begin
          exp_res[p] = 2'b00; exp_dv[p] = 1'b0;
        end
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    logic [NP-1:0] pm;
    for (int p = 0; p < NP; p++) begin
      vectors++;
      if (out_resp[2*p +: 2] !== exp_res[p]) begin
        miscompares++;
        $display("FAIL resp ch%0d cyc%0d: got %b want %b", p, cyc, out_resp[2*p +: 2], exp_res[p]);
      end
      if (exp_dv[p]) begin
        vectors++;
        if (out_data[DW*p +: DW] !== exp_dat[p]) begin
          miscompares++;
          $display("FAIL data ch%0d cyc%0d: got %h want %h", p, cyc, out_data[DW*p +: DW], exp_dat[p]);
        end
      end
      pm[p] = pend_m[p];
    end
    vectors++;
    if (cfg_pend !== pm) begin
      miscompares++;
      $display("FAIL cfg_pend cyc%0d: got %b want %b", cyc, cfg_pend, pm);
    end
    vectors++;
    if (cfg_err !== err_m) begin
      miscompares++;
      $display("FAIL cfg_err cyc%0d: got %b want %b", cyc, cfg_err, err_m);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge c_clk);
    #1;
    check_outputs();
  endtask

  task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic clear_inputs();
    in_resp = '0; cfg_wr = 1'b0; cfg_port = '0; cfg_dly = '0; reset = 1'b0;
  endtask

  task automatic set_ch(input int p, input logic [DW-1:0] d, input logic [1:0] r);
    in_data[DW*p +: DW] = d;
    in_resp[2*p +: 2] = r;
  endtask

  task automatic cfg(input int p, input int d);
    cfg_wr = 1'b1; cfg_port = 3'(p); cfg_dly = DLW'(d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int cnt;
    tbl[0]  = '{1'b1, 3'd5, 3'd0, 1'b1, 4'b0000};
    tbl[1]  = '{1'b1, 3'd1, 3'd4, 1'b1, 4'b0000};
    tbl[2]  = '{1'b1, 3'd7, 3'd7, 1'b1, 4'b0000};
    tbl[3]  = '{1'b1, 3'd2, 3'd3, 1'b0, 4'b0100};
    tbl[4]  = '{1'b0, 3'd0, 3'd0, 1'b0, 4'b0000};
    tbl[5]  = '{1'b1, 3'd0, 3'd0, 1'b0, 4'b0000};
    tbl[6]  = '{1'b1, 3'd3, 3'd1, 1'b0, 4'b1000};
    tbl[7]  = '{1'b1, 3'd3, 3'd2, 1'b0, 4'b1000};
    tbl[8]  = '{1'b0, 3'd0, 3'd0, 1'b0, 4'b0000};
    tbl[9]  = '{1'b1, 3'd3, 3'd2, 1'b0, 4'b0000};
    tbl[10] = '{1'b1, 3'd3, 3'd1, 1'b0, 4'b1000};
    tbl[11] = '{1'b1, 3'd3, 3'd1, 1'b0, 4'b0000};

    // Reset held 3 cycles with responses asserted, then first output one cycle after release.
    reset = 1'b1;
    for (int p = 0; p < NP; p++) set_ch(p, 32'h1111_1111 * (p + 1), 2'b01);
    cfg(1, 2);
    repeat (3) step();
    expect_val("reset out_resp", 32'(out_resp), 32'h0);
    expect_val("reset cfg_pend", 32'(cfg_pend), 32'h0);
    reset = 1'b0; cfg_wr = 1'b0;
    step();
    expect_val("first out after release", 32'(out_resp), 32'h55);

    // Channel 1 at delay 0: one-cycle registered path.
    clear_inputs();
    set_ch(1, 32'hDEAD_BEEF, 2'b01);
    step();
    expect_val("ch1 d0 data", out_data[63:32], 32'hDEAD_BEEF);
    expect_val("ch1 d0 resp", 32'(out_resp[3:2]), 32'h1);
    clear_inputs();
    step();
    expect_val("ch1 d0 resp gone", 32'(out_resp[3:2]), 32'h0);

    // Config table: legality, pend/cancel, simultaneous write with drain-apply.
    for (int i = 0; i < 12; i++) begin
      cfg_wr = tbl[i].wr; cfg_port = tbl[i].port; cfg_dly = tbl[i].dly;
      step();
      expect_val($sformatf("tbl%0d cfg_err", i), 32'(cfg_err), 32'(tbl[i].exp_err));
      expect_val($sformatf("tbl%0d cfg_pend", i), 32'(cfg_pend), 32'(tbl[i].exp_pend));
    end
    clear_inputs();

    // Grow ch2 from 1 to 3 with a response in flight.
    cfg(2, 1); step(); clear_inputs(); step();
    set_ch(2, 32'h0000_0077, 2'b01); cfg(2, 3); step();
    clear_inputs(); step();
    expect_val("ch2 pend while in flight", 32'(cfg_pend[2]), 32'h1);
    step();
    expect_val("ch2 pend after drain", 32'(cfg_pend[2]), 32'h0);
    set_ch(2, 32'h0000_0042, 2'b10);
    found = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      clear_inputs();
      if (found == 0 && out_resp[5:4] == 2'b10 && out_data[95:64] == 32'h42) found = k;
    end
    expect_val("ch2 d3 latency", 32'(found), 32'd4);

    // Shrink ch3 from 3 to 0 with two responses in flight.
    cfg(3, 3); step(); clear_inputs(); step();
    set_ch(3, 32'hA1A1_A1A1, 2'b01); step();
    set_ch(3, 32'hB2B2_B2B2, 2'b11); cfg(3, 0); step();
    clear_inputs();
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (out_resp[7:6] != 2'b00) cnt++;
    end
    expect_val("ch3 shrink resp count", 32'(cnt), 32'd2);
    set_ch(3, 32'hC3C3_C3C3, 2'b01); step(); clear_inputs();
    expect_val("ch3 d0 after shrink", 32'(out_resp[7:6]), 32'h1);
    expect_val("ch3 d0 data", out_data[127:96], 32'hC3C3_C3C3);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 127) == 0);
      for (int p = 0; p < NP; p++)
        set_ch(p, $urandom, ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      cfg_wr   = ($urandom_range(0, 5) == 0);
      cfg_port = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      cfg_dly  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      step();
    end

    // Reset while ch0 is pending with one response in flight.
    clear_inputs();
    repeat (6) step();
    cfg(0, 2); step(); clear_inputs(); repeat (2) step();
    set_ch(0, 32'h0BAD_0BAD, 2'b01); cfg(0, 1); step();
    expect_val("ch0 pend before reset", 32'(cfg_pend[0]), 32'h1);
    clear_inputs(); reset = 1'b1; step();
    expect_val("reset clears pend", 32'(cfg_pend), 32'h0);
    expect_val("reset clears resp", 32'(out_resp), 32'h0);
    reset = 1'b0;
    repeat (4) step();
    set_ch(0, 32'h0000_600D, 2'b01); step(); clear_inputs();
    expect_val("ch0 d0 after reset", 32'(out_resp[1:0]), 32'h1);
    expect_val("ch0 data after reset", out_data[31:0], 32'h0000_600D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
